// File: rtl/updown_count_sequencer.sv
// Command-driven up/down counter sequencer: optional 1-cycle load, then one step per RUN cycle, 1-cycle DONE pulse.
// cmd_ready is high only in IDLE; commands offered while busy are not queued and simply wait for IDLE.
module updown_count_sequencer #(
   parameter int WIDTH  = 3,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              cmd_sat,
   input  logic              cmd_load,
   input  logic [WIDTH-1:0]  cmd_load_val,
   input  logic              pause,
   input  logic              abort,
   output logic [WIDTH-1:0]  q,
   output logic              busy,
   output logic              done,
   output logic              sat_hit,
   output logic              aborted,
   output logic [STEP_W-1:0] steps_left
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

   state_t             state, state_nx;
   logic               dir, dir_nx;
   logic               sat, sat_nx;
   logic [WIDTH-1:0]   load_val, load_val_nx;
   logic [WIDTH-1:0]   q_nx, q_step;
   logic [STEP_W-1:0]  steps_left_nx;
   logic               sat_hit_nx, aborted_nx;
   logic               at_bound;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // Bound depends on direction: max when counting up, zero when counting down.
   assign at_bound = dir ? (q == {WIDTH{1'b1}}) : (q == {WIDTH{1'b0}});
   assign q_step   = dir ? (q + WIDTH'(1)) : (q - WIDTH'(1));

   always_comb begin
      state_nx      = state;
      dir_nx        = dir;
      sat_nx        = sat;
      load_val_nx   = load_val;
      q_nx          = q;
      steps_left_nx = steps_left;
      sat_hit_nx    = sat_hit;
      aborted_nx    = aborted;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               dir_nx        = cmd_dir;
               sat_nx        = cmd_sat;
               load_val_nx   = cmd_load_val;
               steps_left_nx = cmd_steps;
               sat_hit_nx    = 1'b0;
               aborted_nx    = 1'b0;
               if (cmd_load)                    state_nx = LOAD;
               else if (cmd_steps == '0)        state_nx = DONE;
               else                             state_nx = RUN;
            end
         end
         LOAD: begin
            if (abort) begin
               aborted_nx = 1'b1;
               state_nx   = DONE;
            end else begin
               q_nx     = load_val;
               state_nx = (steps_left == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               aborted_nx = 1'b1;
               state_nx   = DONE;
            end else if (pause) begin
               state_nx = PAUSE;
            end else begin
               // A blocked saturating step still consumes its count.
               steps_left_nx = steps_left - STEP_W'(1);
               if (sat && at_bound) sat_hit_nx = 1'b1;
               else                 q_nx       = q_step;
               if (steps_left == STEP_W'(1)) state_nx = DONE;
            end
         end
         PAUSE: begin
            if (abort) begin
               aborted_nx = 1'b1;
               state_nx   = DONE;
            end else if (!pause) begin
               state_nx = RUN;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         dir        <= 1'b0;
         sat        <= 1'b0;
         load_val   <= '0;
         q          <= '0;
         steps_left <= '0;
         sat_hit    <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         state      <= state_nx;
         dir        <= dir_nx;
         sat        <= sat_nx;
         load_val   <= load_val_nx;
         q          <= q_nx;
         steps_left <= steps_left_nx;
         sat_hit    <= sat_hit_nx;
         aborted    <= aborted_nx;
      end
   end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed per-cycle vector table for updown_count_sequencer, plus an async mid-command reset sequence.
module tb_updown_count_sequencer;

   localparam int WIDTH  = 3;
   localparam int STEP_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_dir = 1'b0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic              cmd_sat = 1'b0;
   logic              cmd_load = 1'b0;
   logic [WIDTH-1:0]  cmd_load_val = '0;
   logic              pause = 1'b0;
   logic              abort = 1'b0;
   logic [WIDTH-1:0]  q;
   logic              busy, done, sat_hit, aborted;
   logic [STEP_W-1:0] steps_left;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;
   logic done_seen = 1'b0;

   updown_count_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_sat(cmd_sat),
      .cmd_load(cmd_load), .cmd_load_val(cmd_load_val), .pause(pause),
      .abort(abort), .q(q), .busy(busy), .done(done), .sat_hit(sat_hit),
      .aborted(aborted), .steps_left(steps_left)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mon_en && done) done_seen <= 1'b1;

   // One record = inputs held across one rising edge, outputs expected just after it.
   typedef struct packed {
      logic              v, d;
      logic [STEP_W-1:0] st;
      logic              s, l;
      logic [WIDTH-1:0]  lv;
      logic              p, a;
      logic [WIDTH-1:0]  eq;
      logic              eb, ed, er, esh, eab;
      logic [STEP_W-1:0] esl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, d, input int st, input logic s, l,
                               input int lv, input logic p, a, input int eq,
                               input logic eb, ed, er, esh, eab, input int esl);
      vec_t r;
      r.v = v; r.d = d; r.st = st[STEP_W-1:0]; r.s = s; r.l = l;
      r.lv = lv[WIDTH-1:0]; r.p = p; r.a = a; r.eq = eq[WIDTH-1:0];
      r.eb = eb; r.ed = ed; r.er = er; r.esh = esh; r.eab = eab;
      r.esl = esl[STEP_W-1:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [WIDTH+STEP_W+4:0] got,
                        input logic [WIDTH+STEP_W+4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got q=%0d busy=%b done=%b rdy=%b sat_hit=%b aborted=%b steps_left=%0d, want q=%0d busy=%b done=%b rdy=%b sat_hit=%b aborted=%b steps_left=%0d",
                  name, got[WIDTH+STEP_W+4:STEP_W+5], got[STEP_W+4], got[STEP_W+3],
                  got[STEP_W+2], got[STEP_W+1], got[STEP_W], got[STEP_W-1:0],
                  exp[WIDTH+STEP_W+4:STEP_W+5], exp[STEP_W+4], exp[STEP_W+3],
                  exp[STEP_W+2], exp[STEP_W+1], exp[STEP_W], exp[STEP_W-1:0]);
      end
   endtask

   function automatic logic [WIDTH+STEP_W+4:0] outs();
      return {q, busy, done, cmd_ready, sat_hit, aborted, steps_left};
   endfunction

   task automatic drive(input vec_t r);
      cmd_valid = r.v; cmd_dir = r.d; cmd_steps = r.st; cmd_sat = r.s;
      cmd_load = r.l; cmd_load_val = r.lv; pause = r.p; abort = r.a;
   endtask

   initial begin
      vec_t idle;
      logic found;
      idle = '0;

      // wrap up: load 6, up 4
      vecs.push_back(mk(1,1,4,0,1,6,0,0, 0,1,0,0,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 6,1,0,0,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,0,0,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,0,0,1,0,0,0));
      // saturate down: load 2, down 5
      vecs.push_back(mk(1,0,5,1,1,2,0,0, 2,1,0,0,0,0,5));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,1,0,0,0,0,5));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,1,0,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,1,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,1,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,1,1,0,0));
      // pause: up 5 from 0, pause for 3 edges after q=2
      vecs.push_back(mk(1,1,5,0,0,0,0,0, 0,1,0,0,0,0,5));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,1,0, 2,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,1,0, 2,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,1,0, 2,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 3,1,0,0,0,0,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 4,1,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 5,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,1,0,0,0));
      // abort with pause: load 0, up 6, abort after q=3
      vecs.push_back(mk(1,1,6,0,1,0,0,0, 5,1,0,0,0,0,6));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,0,0,6));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0,0,0,5));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,1,0,0,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 3,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,1,1, 3,1,1,0,0,1,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,1, 3,0,0,1,0,1,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,1, 3,0,0,1,0,1,3));
      // handshake: valid held while busy, then zero-step commands
      vecs.push_back(mk(1,1,3,0,0,0,0,0, 3,1,0,0,0,0,3));
      vecs.push_back(mk(1,0,7,0,1,7,0,0, 4,1,0,0,0,0,2));
      vecs.push_back(mk(1,0,7,0,1,7,0,0, 5,1,0,0,0,0,1));
      vecs.push_back(mk(1,0,7,0,1,7,0,0, 6,1,1,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,0,0, 6,0,0,1,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,0,0, 6,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 6,0,0,1,0,0,0));
      vecs.push_back(mk(1,1,0,0,1,5,0,0, 6,1,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 5,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,1,0,0,0));
      // wrap down from 0
      vecs.push_back(mk(1,0,1,0,1,0,0,0, 5,1,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,1,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,0,0,1,0,0,0));
      // saturate up at max
      vecs.push_back(mk(1,1,2,1,1,6,0,0, 7,1,0,0,0,0,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 6,1,0,0,0,0,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,1,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,1,1,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,0,0,1,1,0,0));
      // abort during LOAD: no load happens
      vecs.push_back(mk(1,1,3,0,1,2,0,0, 7,1,0,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,1, 7,1,1,0,0,1,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,0,0,1,0,1,3));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset", outs(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), outs(),
               {vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].er,
                vecs[i].esh, vecs[i].eab, vecs[i].esl});
      end

      // reset mid-command: load 0, up 5, reset after two steps
      drive(mk(1,1,5,0,1,0,0,0, 0,0,0,0,0,0,0));
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      drive(idle);
      @(posedge clk);
      #1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (q == 3'd2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_wait_q2: got q=%0d, want q=2 within 20 cycles", q);
      end
      #2;
      rst = 1'b0;
      #1;
      check("rst_async", outs(), {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst%0d", k), outs(),
               {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
      end
      checks++;
      if (done_seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_done: got done pulse=%b, want 0", done_seen);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/updown_count_sequencer.md
Name: updown_count_sequencer

Overview:
Command-driven controller that sequences a WIDTH-bit up/down counter. It accepts a command over a valid/ready handshake. Each command carries a direction, a step count, an optional preload and a wrap/saturate mode. The block then runs the counter for that many steps, with pause and abort control, and raises a done pulse. It sits between a host/test controller and the counter datapath, and it owns the counter register, which is exposed on q.

Parameters:
WIDTH, 3, counter width; q range 0..2^WIDTH-1
STEP_W, 8, width of step-count field; max 2^STEP_W-1 steps per command

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_dir  input  1  1 = count up, 0 = count down
cmd_steps  input  STEP_W  number of steps to perform
cmd_sat  input  1  0 = wrap at bounds, 1 = saturate at bounds
cmd_load  input  1  preload q with cmd_load_val before stepping
cmd_load_val  input  WIDTH  preload value
pause  input  1  hold stepping while high
abort  input  1  terminate current command
q  output  WIDTH  counter value
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at command completion or abort
sat_hit  output  1  a saturating step was blocked during the current or last command
aborted  output  1  last command ended by abort
steps_left  output  STEP_W  remaining steps of the current or last command

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE; q=0; steps_left=0.
  - done=0, busy=0, sat_hit=0, aborted=0.
  - cmd_ready=1 once rst=1.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Accept condition: cmd_valid & cmd_ready, sampled at edge E0.
- At E0:
  - Latch dir, sat and steps into steps_left.
  - Clear sat_hit and aborted.
  - Next state: LOAD if cmd_load; else DONE if cmd_steps=0; else RUN.
- cmd_valid while not in IDLE is ignored; no queuing.
- LOAD (1 cycle): q <= cmd_load_val (latched at E0). Next state is DONE if steps=0, else RUN.
- RUN, each edge with pause=0 and abort=0:
  - One step: up q+1, down q-1. steps_left decrements.
  - If steps_left was 1, next state is DONE.
- Step arithmetic:
  - Wrap mode is modulo 2^WIDTH: up from max gives 0; down from 0 gives max.
  - Saturate mode: up at max or down at 0 leaves q unchanged and sets sat_hit. The step is still consumed and steps_left still decrements.
- Latency, no load:
  - Steps occur at edges E1..EN; DONE during the cycle after EN; IDLE after E(N+1).
  - With load: the load occurs at E1, steps at E2..E(N+1), one cycle later throughout.
- Pause:
  - RUN with pause=1: no step; next state PAUSE.
  - PAUSE with pause=0: next state RUN, with no step on that edge. Resume therefore costs one cycle.
  - q and steps_left are frozen in PAUSE.
- Abort:
  - Priority is abort > pause > step.
  - abort=1 in LOAD, RUN or PAUSE: next state DONE; no step or load on that edge.
  - q holds and steps_left keeps the remaining count. aborted <= 1.
  - abort in IDLE or DONE has no effect.
- DONE (exactly 1 cycle): done=1, cmd_ready=0, then IDLE.
- Outputs are registered; done is derived from the state register.
- sat_hit, aborted and steps_left hold their values in IDLE until the next accept.
- busy=1 in LOAD/RUN/PAUSE/DONE.
- cmd_ready=1 only in IDLE. A new command is accepted on the first IDLE edge after DONE, so back-to-back commands have one idle cycle.
- Reset mid-command returns everything to reset values immediately. No done pulse is issued.

Test Plan:
- Reset mid-command: start up/5 from 0 and assert rst=0 after 2 steps -> q=0, busy=0, done never pulses, cmd_ready=1 after release.
- Wrap up: load=1, load_val=6, dir=1, steps=4, sat=0 -> q: 6,7,0,1,2 at E1..E5; done high for the cycle after E5; sat_hit=0, steps_left=0.
- Saturate down: load 2, dir=0, steps=5, sat=1 -> q: 2,1,0,0,0,0; sat_hit=1; done after the 5th step; steps_left=0.
- Pause: q=0, up, steps=5, no load; pause=1 for 3 cycles after q=2 -> q holds 2 for 4 cycles, then 3,4,5; done once; steps_left=0.
- Abort: up/6 from 0, abort=1 (with pause=1) after q=3 -> next cycle done=1, q=3, steps_left=3, aborted=1; abort then has no effect in IDLE.
- Handshake: cmd_valid held high during busy -> no second accept until IDLE. A steps=0 command without load -> done during the cycle after E0 and q unchanged. A steps=0 command with load=5 -> q=5, then done.
